conv_seq_ctrl: RTL
==================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter N, default 8, data bit width of pixels and outputs.
REQ-002 Parameter INPUT_SIZE, default 6, square input feature-map side.
REQ-003 Parameter KERNEL_SIZE, default 3, square kernel side.
REQ-004 Parameter STRIDE, default 1, convolution stride. OUT_SIZE = (INPUT_SIZE-KERNEL_SIZE)/STRIDE+1.
REQ-005 Parameter OUT_CH, default 4, number of output channels sequenced per start.
REQ-006 Parameter DRAIN_MAX, default 64, maximum number of DRAIN cycles before timeout.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle request to run a full layer; ignored unless the FSM is in IDLE.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when the layer completes.
REQ-012 err  out  1  sticky DRAIN timeout flag; cleared on start.
REQ-013 ch_idx  out  $clog2(OUT_CH)  current output channel; selects weight/bias/shift ROM.
REQ-014 in_rd / in_addr  out  1 / $clog2(INPUT_SIZE^2)  feature-map RAM read strobe and address; RAM read latency is 1 cycle.
REQ-015 in_rdata  in  N  feature-map RAM read data.
REQ-016 conv_ce / conv_vld / conv_din  out  1 / 1 / N  enable, pixel-valid and pixel drive to the conv datapath.
REQ-017 conv_dout / conv_dout_vld  in  N / 1  result and result-valid from the conv datapath.
REQ-018 out_wr / out_addr / out_data  out  1 / $clog2(OUT_CH*OUT_SIZE^2) / N  output RAM write port.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, STREAM, DRAIN, NEXT and FIN.
REQ-020 IDLE->LOAD on start; LOAD lasts exactly 1 cycle so the weight ROM output settles for ch_idx.
REQ-021 LOAD->STREAM. In STREAM, in_rd=1 and in_addr increments 0..INPUT_SIZE^2-1, one per cycle, row-major.
REQ-022 STREAM->DRAIN in the cycle after the read of address INPUT_SIZE^2-1.
REQ-023 conv_vld = in_rd delayed 1 cycle; conv_din = in_rdata in the same cycle, so the input stream is gap-free.
REQ-024 conv_ce SHALL be 1 in LOAD, STREAM and DRAIN, and 0 otherwise.
REQ-025 Each cycle with conv_dout_vld=1 in STREAM or DRAIN SHALL assert out_wr, with out_data=conv_dout and out_addr=ch_idx*OUT_SIZE^2+res_cnt; res_cnt then increments.
REQ-026 conv_dout_vld in IDLE, LOAD, NEXT or FIN SHALL be ignored: no write and no count.
REQ-027 DRAIN->NEXT when res_cnt reaches OUT_SIZE^2, including a result arriving in that same cycle.
REQ-028 DRAIN->NEXT also when the drain counter reaches DRAIN_MAX; this sets err=1 and processing continues with the next channel.
REQ-029 In NEXT, res_cnt is cleared and ch_idx increments. Then: if ch_idx was OUT_CH-1, go to FIN; otherwise go to LOAD.
REQ-030 FIN SHALL pulse done=1 for 1 cycle, return to IDLE and reset ch_idx to 0.
REQ-031 A start arriving in the same cycle as the FIN->IDLE transition SHALL be ignored; start is accepted only while the FSM is in IDLE.
REQ-032 All counters are unsigned, and out_addr SHALL never exceed OUT_CH*OUT_SIZE^2-1.

Reset
REQ-033 rst_n=0 SHALL immediately set the state to IDLE.
REQ-034 rst_n=0 SHALL immediately clear busy, done, err, in_rd, in_addr, conv_ce, conv_vld, conv_din, out_wr, out_addr, out_data, ch_idx, res_cnt and the drain counter to 0.
REQ-035 A reset during STREAM or DRAIN SHALL abort the layer without a done pulse. The next start SHALL restart at channel 0 and address 0.

Verification
REQ-036 Defaults with OUT_CH=2 and a model datapath returning 16 results per channel: start -> 36 reads per channel, addresses 0..35; 32 writes to out_addr 0..31; exactly one done pulse; err=0.
REQ-037 Pulse start while busy -> ignored; a single layer run and a single done pulse.
REQ-038 Model returns only 15 results on channel 0 -> after 64 DRAIN cycles err=1; channel 1 writes begin at out_addr 16; done is still asserted.
REQ-039 Assert rst_n=0 at read address 20 of channel 1 -> all outputs are 0 and there is no done pulse. A subsequent start -> in_addr 0, ch_idx 0.
REQ-040 Inject conv_dout_vld pulses while in IDLE -> out_wr stays 0.
REQ-041 Check the continuous stream: conv_vld is high for exactly 36 consecutive cycles per channel, and conv_din equals the RAM contents in address order.

Source files
------------

// File: rtl/conv_seq_if.sv
// conv_seq_if -- bundles the convolution sequencer's handshake and memory
// ports into one interface.
//   master : the sequencer (drives strobes, addresses, status)
//   slave  : the environment (host start, feature-map RAM, conv datapath,
//            output RAM)
// Signals:
//   start / busy / done / err    layer control and status
//   ch_idx                       current output channel (ROM select)
//   in_rd / in_addr / in_rdata   feature-map RAM read port (1-cycle latency)
//   conv_ce / conv_vld / conv_din     drive to the conv datapath
//   conv_dout / conv_dout_vld    results from the conv datapath
//   out_wr / out_addr / out_data output RAM write port
interface conv_seq_if #(
  parameter int N           = 8,
  parameter int INPUT_SIZE  = 6,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int OUT_CH      = 4
);
  localparam int OUT_SIZE = (INPUT_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int CH_W     = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int IN_AW    = $clog2(INPUT_SIZE * INPUT_SIZE);
  localparam int OUT_AW   = $clog2(OUT_CH * OUT_SIZE * OUT_SIZE);

  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [CH_W-1:0]   ch_idx;
  logic              in_rd;
  logic [IN_AW-1:0]  in_addr;
  logic [N-1:0]      in_rdata;
  logic              conv_ce;
  logic              conv_vld;
  logic [N-1:0]      conv_din;
  logic [N-1:0]      conv_dout;
  logic              conv_dout_vld;
  logic              out_wr;
  logic [OUT_AW-1:0] out_addr;
  logic [N-1:0]      out_data;

  modport master (
    input  start, in_rdata, conv_dout, conv_dout_vld,
    output busy, done, err, ch_idx, in_rd, in_addr,
           conv_ce, conv_vld, conv_din, out_wr, out_addr, out_data
  );

  modport slave (
    output start, in_rdata, conv_dout, conv_dout_vld,
    input  busy, done, err, ch_idx, in_rd, in_addr,
           conv_ce, conv_vld, conv_din, out_wr, out_addr, out_data
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl -- sequences one convolution layer: for every output
// channel it loads the channel's weights, streams the whole input feature
// map to the conv datapath, collects OUT_SIZE^2 results into the output RAM
// and moves on; a pulse on done marks the end of the layer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    conv_seq_if.master (control, feature-map RAM, datapath, out RAM)
module conv_seq_ctrl #(
  parameter int N           = 8,
  parameter int INPUT_SIZE  = 6,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int OUT_CH      = 4,
  parameter int DRAIN_MAX   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  conv_seq_if.master bus
);

  localparam int OUT_SIZE   = (INPUT_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int RES_PER_CH = OUT_SIZE * OUT_SIZE;
  localparam int PIX        = INPUT_SIZE * INPUT_SIZE;
  localparam int CH_W       = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int IN_AW      = $clog2(PIX);
  localparam int OUT_AW     = $clog2(OUT_CH * RES_PER_CH);
  localparam int RW         = $clog2(RES_PER_CH + 1);
  localparam int DW         = $clog2(DRAIN_MAX + 1);

  localparam logic [IN_AW-1:0] RD_LAST    = IN_AW'(PIX - 1);
  localparam logic [RW-1:0]    RES_MAX    = RW'(RES_PER_CH);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_MAX - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(OUT_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_FIN
  } state_e;

  state_e             state_q,     state_d;
  logic [IN_AW-1:0]   rd_addr_q,   rd_addr_d;
  logic [RW-1:0]      res_cnt_q,   res_cnt_d;
  logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [CH_W-1:0]    ch_idx_q,    ch_idx_d;
  logic               err_q,       err_d;
  logic               conv_vld_q;
  logic               wr_en;
  logic [OUT_AW-1:0]  out_base;

  // A result is only stored while a channel is being processed, and never
  // beyond the channel's last slot, so out_addr cannot leave the channel's
  // region even if the datapath over-produces.
  assign wr_en = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                 bus.conv_dout_vld && (res_cnt_q < RES_MAX);

  assign out_base = OUT_AW'(ch_idx_q) * OUT_AW'(RES_PER_CH);

  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    res_cnt_d   = res_cnt_q;
    drain_cnt_d = '0;
    ch_idx_d    = ch_idx_q;
    err_d       = err_q;

    if (wr_en) begin
      res_cnt_d = res_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_LOAD;
          err_d     = 1'b0;
          ch_idx_d  = '0;
          rd_addr_d = '0;
          res_cnt_d = '0;
        end
      end
      // One cycle for the weight ROM to settle on the new ch_idx.
      S_LOAD: state_d = S_STREAM;
      S_STREAM: begin
        if (rd_addr_q == RD_LAST) begin
          rd_addr_d = '0;
          state_d   = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // res_cnt_d already includes a result landing in this cycle.
        if (res_cnt_d == RES_MAX) begin
          state_d = S_NEXT;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_NEXT;
          err_d   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        res_cnt_d = '0;
        if (ch_idx_q == CH_LAST) begin
          state_d = S_FIN;
        end else begin
          ch_idx_d = ch_idx_q + 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_FIN: begin
        ch_idx_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      res_cnt_q   <= '0;
      drain_cnt_q <= '0;
      ch_idx_q    <= '0;
      err_q       <= 1'b0;
      conv_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      res_cnt_q   <= res_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ch_idx_q    <= ch_idx_d;
      err_q       <= err_d;
      // RAM data returns one cycle after the strobe; the matching delayed
      // valid keeps the pixel stream gap-free.
      conv_vld_q  <= (state_q == S_STREAM);
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_FIN);
  assign bus.err     = err_q;
  assign bus.ch_idx  = ch_idx_q;
  assign bus.in_rd   = (state_q == S_STREAM);
  assign bus.in_addr = rd_addr_q;
  assign bus.conv_ce = (state_q == S_LOAD) || (state_q == S_STREAM) ||
                       (state_q == S_DRAIN);
  assign bus.conv_vld = conv_vld_q;
  // NOTE: pass-through data is gated by its qualifier so it reads 0 while
  // idle or in reset instead of echoing whatever the RAM or datapath holds.
  assign bus.conv_din = conv_vld_q ? bus.in_rdata : '0;
  assign bus.out_wr   = wr_en;
  assign bus.out_addr = wr_en ? (out_base + OUT_AW'(res_cnt_q)) : '0;
  assign bus.out_data = wr_en ? bus.conv_dout : '0;

endmodule
